// File: rtl/toggle_pkg.sv
// toggle_pkg: shared types and constants for the toggle-stage driver.
//   toggle_state_t  - driver FSM state (IDLE, RUN, DRAIN, DONE)
//   LFSR_TAPS       - Galois feedback mask for the 8-bit right-shift LFSR
//   LFSR_ZERO_SEED  - substitute seed when 0x00 is requested (LFSR lock-up)
//   lfsr_step()     - one LFSR advance
package toggle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } toggle_state_t;

    localparam logic [7:0] LFSR_TAPS      = 8'hB8;
    localparam logic [7:0] LFSR_ZERO_SEED = 8'h01;

    // Right shift; the bit shifted out of [0] selects the feedback XOR.
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/toggle_driver_if.sv
// toggle_driver_if: control handshake plus the en/q -> z link of the driver.
//   start/len/seed : run request (len and seed sampled with an accepted start)
//   busy/done      : run status
//   err_cnt        : mismatches in current/last run
//   first_err      : beat index of first mismatch (valid when err_cnt != 0)
//   en_o/q_o       : beat driven into the toggle stage
//   z_i            : toggle stage output
//
// Handshake: start is accepted only on a clock edge where the driver is
// idle (busy=0, done=0); any other start is ignored. busy rises the cycle
// after acceptance and stays high until the single-cycle done pulse, during
// which busy is low. err_cnt/first_err are final in the done cycle and hold
// until the next accepted start.
interface toggle_driver_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic [7:0]       seed;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [LEN_W-1:0] first_err;
    logic             en_o;
    logic             q_o;
    logic             z_i;

    modport master (
        input  start, len, seed, z_i,
        output busy, done, err_cnt, first_err, en_o, q_o
    );

    modport slave (
        output start, len, seed, z_i,
        input  busy, done, err_cnt, first_err, en_o, q_o
    );
endinterface

// File: rtl/toggle_lfsr8.sv
// toggle_lfsr8: 8-bit Galois LFSR with synchronous load and step.
//   clk, reset (async, active-low) ; load/seed : load seed (0x00 -> 0x01)
//   step : advance one position    ; state : current LFSR value
module toggle_lfsr8
    import toggle_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] state
);

    logic [7:0] lfsr_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_r <= LFSR_ZERO_SEED;
        end else if (load) begin
            // An all-zero LFSR would never leave zero.
            lfsr_r <= (seed == 8'h00) ? LFSR_ZERO_SEED : seed;
        end else if (step) begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign state = lfsr_r;

endmodule

// File: rtl/toggle_driver.sv
// toggle_driver: LFSR stimulus generator and self-checker for the
// single-bit toggle stage. Drives en_o/q_o for len beats and checks that
// z_i equals q_o one cycle after every enabled beat.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low
//   bus       : toggle_driver_if master (handshake, results, en/q/z link)
//   dbg_state : current FSM state
module toggle_driver
    import toggle_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    toggle_driver_if.master        bus,
    output toggle_state_t          dbg_state
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    toggle_state_t    state, state_nxt;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] idx_r;
    logic [7:0]       lfsr_q;
    logic             accept;
    logic             step;
    logic             en_d;
    logic             q_d;

    // Check pipeline: what was driven last cycle, and its beat index.
    logic             chk_r;
    logic             exp_r;
    logic [LEN_W-1:0] cidx_r;
    logic             mismatch;

    logic [CNT_W-1:0] err_r;
    logic [LEN_W-1:0] first_r;

    assign accept = (state == ST_IDLE) && bus.start;

    toggle_lfsr8 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .seed  (bus.seed),
        .step  (step),
        .state (lfsr_q)
    );

    always_comb begin
        state_nxt = state;
        step      = 1'b0;
        en_d      = 1'b0;
        q_d       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.len != '0) ? ST_RUN : ST_DRAIN;
                end
            end
            ST_RUN: begin
                en_d = lfsr_q[0];
                q_d  = lfsr_q[1];
                step = 1'b1;
                if (idx_r == len_r - LEN_W'(1)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign mismatch = chk_r && (bus.z_i != exp_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_r   <= '0;
            idx_r   <= '0;
            chk_r   <= 1'b0;
            exp_r   <= 1'b0;
            cidx_r  <= '0;
            err_r   <= '0;
            first_r <= '0;
        end else begin
            chk_r  <= en_d;
            exp_r  <= q_d;
            cidx_r <= idx_r;
            if (accept) begin
                len_r   <= bus.len;
                idx_r   <= '0;
                err_r   <= '0;
                first_r <= '0;
            end else begin
                if (state == ST_RUN) begin
                    idx_r <= idx_r + LEN_W'(1);
                end
                if (mismatch) begin
                    if (err_r != CNT_MAX) begin
                        err_r <= err_r + CNT_W'(1);
                    end
                    if (err_r == '0) begin
                        first_r <= cidx_r;
                    end
                end
            end
        end
    end

    assign bus.en_o      = en_d;
    assign bus.q_o       = q_d;
    assign bus.busy      = (state == ST_RUN) || (state == ST_DRAIN);
    assign bus.done      = (state == ST_DONE);
    assign bus.err_cnt   = err_r;
    assign bus.first_err = first_r;
    assign dbg_state     = state;

endmodule
